// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
// Rate-1/2 feed-forward convolutional encoder. Each accepted information bit
// produces a pair of coded bits (G0 first, then G1). The pair is sent out
// serially on y, one bit per clock. The encoder takes a new input bit at most
// every second cycle.
//
// Parameters:
//   K   constraint length (K >= 2); the shift register holds K-1 past bits
//   G0  first generator polynomial, bit K-1 taps the current input
//   G1  second generator polynomial, bit K-1 taps the current input
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active high
//   x           information bit
//   x_valid     x is valid this cycle
//   x_ready     encoder accepts x this cycle (combinational, from state only)
//   y           serialized coded bit (registered)
//   y_valid     y carries a coded bit (registered)
//   y_first     y is the G0 bit of a pair (registered)
//   flush       request trellis termination (CONV_ENCODER_TAIL_FLUSH_EN only)
//   flush_busy  tail zeros pending or being encoded (CONV_ENCODER_TAIL_FLUSH_EN only)
//
// Optional feature macro: CONV_ENCODER_TAIL_FLUSH_EN
//   When defined, a flush request feeds K-1 zero bits through the encoder so
//   that the shift register returns to the all-zero state.
//
// phase      | meaning
// PH_ACCEPT  | accept slot: encode x (or a tail zero) and emit its G0 bit
// PH_SECOND  | second-bit slot: emit the held G1 bit, inputs ignored
// ---------------------------------------------------------------------------
module conv_encoder #(
  parameter int           K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic x_valid,
  output logic x_ready,
  output logic y,
  output logic y_valid,
  output logic y_first
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
  ,
  input  logic flush,
  output logic flush_busy
`endif
);

  typedef enum logic {
    PH_ACCEPT = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  phase_t       phase, phase_nxt;
  logic [K-2:0] regs, regs_nxt;
  logic         c1_hold, c1_hold_nxt;
  logic         y_nxt, y_valid_nxt, y_first_nxt;

  logic         take;
  logic         x_in;
  logic [K-1:0] w;
  logic         c0, c1;

`ifdef CONV_ENCODER_TAIL_FLUSH_EN
  localparam int CW = $clog2(K);

  logic [CW-1:0] tail_cnt, tail_cnt_nxt;
  logic          tail_pair, tail_pair_nxt;
  logic          tail_active;

  assign tail_active = (tail_cnt != '0);
  // Busy covers the tail accept slots plus the G1 slot of the last tail pair.
  assign flush_busy  = tail_active | tail_pair;
  assign x_ready     = (phase == PH_ACCEPT) & ~tail_active;
`else
  assign x_ready     = (phase == PH_ACCEPT);
`endif

  always_comb begin
    take = (phase == PH_ACCEPT) && x_valid;
    x_in = x;
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
    // Tail slots encode a forced zero regardless of x_valid.
    if (tail_active) begin
      take = (phase == PH_ACCEPT);
      x_in = 1'b0;
    end
`endif
    w  = {x_in, regs};
    c0 = ^(G0 & w);
    c1 = ^(G1 & w);
  end

  always_comb begin
    phase_nxt   = phase;
    regs_nxt    = regs;
    c1_hold_nxt = c1_hold;
    y_nxt       = 1'b0;
    y_valid_nxt = 1'b0;
    y_first_nxt = 1'b0;
    if (phase == PH_SECOND) begin
      y_nxt       = c1_hold;
      y_valid_nxt = 1'b1;
      phase_nxt   = PH_ACCEPT;
    end else if (take) begin
      y_nxt       = c0;
      y_valid_nxt = 1'b1;
      y_first_nxt = 1'b1;
      c1_hold_nxt = c1;
      regs_nxt    = w[K-1:1];
      phase_nxt   = PH_SECOND;
    end
  end

`ifdef CONV_ENCODER_TAIL_FLUSH_EN
  always_comb begin
    tail_cnt_nxt  = tail_cnt;
    tail_pair_nxt = 1'b0;
    if (take && tail_active) begin
      tail_cnt_nxt  = tail_cnt - CW'(1);
      tail_pair_nxt = 1'b1;
    end
    // A flush arriving with an accepted x simply queues the tail behind it.
    if (flush && !flush_busy) begin
      tail_cnt_nxt = CW'(K - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_cnt  <= '0;
      tail_pair <= 1'b0;
    end else begin
      tail_cnt  <= tail_cnt_nxt;
      tail_pair <= tail_pair_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= PH_ACCEPT;
      regs    <= '0;
      c1_hold <= 1'b0;
      y       <= 1'b0;
      y_valid <= 1'b0;
      y_first <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      regs    <= regs_nxt;
      c1_hold <= c1_hold_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      y_first <= y_first_nxt;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

  logic clk = 1'b0;
  logic rst;
  logic x;
  logic x_valid;
  logic x_ready;
  logic y;
  logic y_valid;
  logic y_first;
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
  logic flush;
  logic flush_busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  conv_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_first (y_first)
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
    ,
    .flush      (flush),
    .flush_busy (flush_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 1'b1; x_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({y, y_valid, y_first} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got y/yv/yf=%b%b%b expected 000", i, y, y_valid, y_first);
      end
    end
    rst = 1'b0; x_valid = 1'b0;
    #1;
    n_checks++;
    if (x_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_x_ready: got %b expected 1", x_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] bits;
    logic [1:0] pairs [7];
    bits = 7'b1101000;
    pairs = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (x_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready0 bit %0d: got %b expected 1", i, x_ready);
      end
      x = bits[6-i]; x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      n_checks++;
      if ({y, y_valid, y_first} !== {pairs[i][1], 2'b11}) begin
        n_fail++;
        $display("FAIL b2b_g0 bit %0d: got y/yv/yf=%b%b%b expected %b11", i, y, y_valid, y_first, pairs[i][1]);
      end
      n_checks++;
      if (x_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready1 bit %0d: got %b expected 0", i, x_ready);
      end
      tick();
      n_checks++;
      if ({y, y_valid, y_first} !== {pairs[i][0], 2'b10}) begin
        n_fail++;
        $display("FAIL b2b_g1 bit %0d: got y/yv/yf=%b%b%b expected %b10", i, y, y_valid, y_first, pairs[i][0]);
      end
    end
  endtask

  task automatic test_gap();
    // State is all zero after the back-to-back tail of zeros.
    x = 1'b1; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b111) begin
      n_fail++;
      $display("FAIL gap_first_g0: got %b%b%b expected 111", y, y_valid, y_first);
    end
    tick();
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b110) begin
      n_fail++;
      $display("FAIL gap_first_g1: got %b%b%b expected 110", y, y_valid, y_first);
    end
    for (int i = 0; i < 3; i++) begin
      x = 1'b1;
      tick();
      n_checks++;
      if ({y, y_valid, y_first} !== 3'b000) begin
        n_fail++;
        $display("FAIL gap_idle cycle %0d: got %b%b%b expected 000", i, y, y_valid, y_first);
      end
    end
    x = 1'b1; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b011) begin
      n_fail++;
      $display("FAIL gap_second_g0: got %b%b%b expected 011", y, y_valid, y_first);
    end
    tick();
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b110) begin
      n_fail++;
      $display("FAIL gap_second_g1: got %b%b%b expected 110", y, y_valid, y_first);
    end
  endtask

  task automatic test_phase1_block();
    logic [7:0] xs;
    logic [7:0] ys;
    rst = 1'b1; x_valid = 1'b0;
    tick();
    rst = 1'b0;
    // Accepted bits (even cycles) are 1,0,1,0 -> pairs 11,10,00,10.
    xs = 8'b10011001;
    ys = 8'b11100010;
    x_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = xs[7-i];
      #1;
      n_checks++;
      if (x_ready !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL block_ready cycle %0d: got %b expected %b", i, x_ready, (i % 2) == 0);
      end
      tick();
      n_checks++;
      if ({y, y_valid, y_first} !== {ys[7-i], 1'b1, (i % 2) == 0}) begin
        n_fail++;
        $display("FAIL block_y cycle %0d: got %b%b%b expected %b1%b", i, y, y_valid, y_first, ys[7-i], (i % 2) == 0);
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic test_mid_pair_reset();
    x = 1'b1; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_out: got %b%b%b expected 000", y, y_valid, y_first);
    end
    n_checks++;
    if (x_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b expected 1", x_ready);
    end
    tick();
    n_checks++;
    if (y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_g1: got y_valid %b expected 0", y_valid);
    end
    x = 1'b1; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b111) begin
      n_fail++;
      $display("FAIL midrst_g0: got %b%b%b expected 111", y, y_valid, y_first);
    end
    tick();
    n_checks++;
    if ({y, y_valid, y_first} !== 3'b110) begin
      n_fail++;
      $display("FAIL midrst_g1: got %b%b%b expected 110", y, y_valid, y_first);
    end
  endtask

`ifdef CONV_ENCODER_TAIL_FLUSH_EN
  task automatic test_flush();
    logic [3:0] ys;
    rst = 1'b1; x_valid = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = 1'b1; x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      tick();
    end
    n_checks++;
    if (flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_busy: got %b expected 0", flush_busy);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ys = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({flush_busy, x_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL flush_busy cycle %0d: got busy/ready=%b%b expected 10", i, flush_busy, x_ready);
      end
      tick();
      n_checks++;
      if ({y, y_valid, y_first} !== {ys[3-i], 1'b1, (i % 2) == 0}) begin
        n_fail++;
        $display("FAIL flush_tail cycle %0d: got %b%b%b expected %b1%b", i, y, y_valid, y_first, ys[3-i], (i % 2) == 0);
      end
    end
    n_checks++;
    if ({flush_busy, x_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_done: got busy/ready=%b%b expected 01", flush_busy, x_ready);
    end
    x = 1'b1; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    tick();
    n_checks++;
    if ({y, y_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_cleared: got %b%b expected 11", y, y_valid);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; x = 1'b0; x_valid = 1'b0;
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_gap();
    test_phase1_block();
    test_mid_pair_reset();
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
